// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl shared definitions: register offsets
// and controller state encoding.
package irq_ctrl_pkg;

  localparam logic [2:0] IRQ_PENDING  = 3'd0;
  localparam logic [2:0] IRQ_ENABLE   = 3'd1;
  localparam logic [2:0] IRQ_CLAIM    = 3'd2;
  localparam logic [2:0] IRQ_COMPLETE = 3'd3;
  localparam logic [2:0] IRQ_STATUS   = 3'd4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_ctrl_if.sv
// MMIO register bus between the CPU and irq_ctrl.
// spo is combinational from a and block state.
interface irq_ctrl_if;
  logic [2:0]  a;
  logic [31:0] d;
  logic        we;
  logic        rd;
  logic [31:0] spo;

  modport master (
    output a, d, we, rd,
    input  spo
  );

  modport slave (
    input  a, d, we, rd,
    output spo
  );
endinterface

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set index wins.
// Combinational; id is valid only when o_valid.
module irq_prio_enc #(
  parameter int N = 4
) (
  input  logic [N-1:0] i_req,
  output logic         o_valid,
  output logic [4:0]   o_id
);

  always_comb begin
    o_valid = 1'b0;
    o_id    = 5'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_valid = 1'b1;
        o_id    = 5'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge latch, mask, fixed
// priority, claim/complete with one in service.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int          NSRC       = 4,
  parameter logic [31:0] ENABLE_RST = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NSRC-1:0] src,
  output logic            irq,
  irq_ctrl_if.slave       bus
);

  logic [NSRC-1:0] r_src_d;
  logic [NSRC-1:0] r_pend;
  logic [NSRC-1:0] r_en;
  logic            r_arm;
  irq_state_e      r_state;
  logic            r_irq;
  logic [4:0]      r_claimed;
  logic            r_in_service;

  logic [NSRC-1:0] w_rise;
  logic [NSRC-1:0] w_req;
  logic [NSRC-1:0] w_sel;
  logic [NSRC-1:0] w_clr;
  logic            w_valid;
  logic [4:0]      w_id;
  logic            w_wr_pend;
  logic            w_wr_en;
  logic            w_claim;
  logic            w_done;
  logic            w_unused;

  assign w_unused = &{1'b0, bus.d};

  // r_arm masks the first cycle after reset so a
  // level already high at release is not an edge.
  assign w_rise = src & ~r_src_d & {NSRC{r_arm}};
  assign w_req  = r_pend & r_en;

  irq_prio_enc #(
    .N (NSRC)
  ) u_enc (
    .i_req   (w_req),
    .o_valid (w_valid),
    .o_id    (w_id)
  );

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NSRC; i++) begin
      w_sel[i] = (w_id == 5'(i));
    end
  end

  assign w_wr_pend = bus.we && (bus.a == IRQ_PENDING);
  assign w_wr_en   = bus.we && (bus.a == IRQ_ENABLE);

  assign w_claim = bus.rd
                && (bus.a == IRQ_CLAIM)
                && w_valid
                && (r_state != SERVICE);

  assign w_done = bus.we
               && (bus.a == IRQ_COMPLETE)
               && (r_state == SERVICE)
               && (bus.d[4:0] == r_claimed);

  assign w_clr = (w_wr_pend ? bus.d[NSRC-1:0] : '0)
               | (w_claim ? w_sel : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src_d <= '0;
      r_arm   <= 1'b0;
      r_pend  <= '0;
      r_en    <= ENABLE_RST[NSRC-1:0];
    end else begin
      r_src_d <= src;
      r_arm   <= 1'b1;
      r_pend  <= (r_pend & ~w_clr) | w_rise;
      if (w_wr_en) begin
        r_en <= bus.d[NSRC-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_irq        <= 1'b0;
      r_claimed    <= 5'd0;
      r_in_service <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_claim) begin
            r_state      <= SERVICE;
            r_irq        <= 1'b0;
            r_claimed    <= w_id + 5'd1;
            r_in_service <= 1'b1;
          end else if (w_valid) begin
            r_state <= ASSERT;
            r_irq   <= 1'b1;
          end
        end
        ASSERT: begin
          if (w_claim) begin
            r_state      <= SERVICE;
            r_irq        <= 1'b0;
            r_claimed    <= w_id + 5'd1;
            r_in_service <= 1'b1;
          end else if (!w_valid) begin
            r_state <= IDLE;
            r_irq   <= 1'b0;
          end
        end
        SERVICE: begin
          r_irq <= 1'b0;
          if (w_done) begin
            r_state      <= IDLE;
            r_claimed    <= 5'd0;
            r_in_service <= 1'b0;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_irq        <= 1'b0;
          r_claimed    <= 5'd0;
          r_in_service <= 1'b0;
        end
      endcase
    end
  end

  assign irq = r_irq;

  always_comb begin
    bus.spo = 32'd0;
    case (bus.a)
      IRQ_PENDING: bus.spo = 32'(r_pend);
      IRQ_ENABLE:  bus.spo = 32'(r_en);
      IRQ_CLAIM: begin
        if (w_valid && (r_state != SERVICE)) begin
          bus.spo = 32'(w_id) + 32'd1;
        end
      end
      IRQ_STATUS: begin
        bus.spo = {26'd0, r_in_service, r_claimed};
      end
      default: bus.spo = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: latch, mask, priority,
// claim/complete, W1C races and async reset.
module tb_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] src = '0;
  logic       irq;
  int         n_pass = 0;
  int         n_tot = 0;
  logic [31:0] v;

  irq_ctrl_if bus ();

  irq_ctrl #(
    .NSRC       (4),
    .ENABLE_RST (32'd0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .src   (src),
    .irq   (irq),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic peek(input logic [2:0] addr,
                      output logic [31:0] val);
    bus.a = addr;
    #1;
    val = bus.spo;
  endtask

  task automatic claim(output logic [31:0] val);
    bus.a  = 3'd2;
    bus.rd = 1'b1;
    #1;
    val = bus.spo;
    @(negedge clk);
    bus.rd = 1'b0;
  endtask

  task automatic wr(input logic [2:0] addr,
                    input logic [31:0] data);
    bus.a  = addr;
    bus.d  = data;
    bus.we = 1'b1;
    @(negedge clk);
    bus.we = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] m);
    src = src | m;
    @(negedge clk);
    src = src & ~m;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(2);
    n_tot++;
    if (irq !== 1'b0) $display("FAIL rst_irq got %b want 0", irq);
    else n_pass++;
    peek(3'd0, v);
    n_tot++;
    if (v !== 32'h0) $display("FAIL rst_pend got %h want 0", v);
    else n_pass++;
    peek(3'd1, v);
    n_tot++;
    if (v !== 32'h0) $display("FAIL rst_en got %h want 0", v);
    else n_pass++;
    peek(3'd4, v);
    n_tot++;
    if (v !== 32'h0) $display("FAIL rst_stat got %h want 0", v);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic test_mask_latch();
    pulse(4'b0001);
    peek(3'd0, v);
    n_tot++;
    if (v !== 32'h1) $display("FAIL mask_pend got %h want 1", v);
    else n_pass++;
    cyc(2);
    n_tot++;
    if (irq !== 1'b0) $display("FAIL mask_irq got %b want 0", irq);
    else n_pass++;
    wr(3'd1, 32'h1);
    n_tot++;
    if (irq !== 1'b0) $display("FAIL en_irq1 got %b want 0", irq);
    else n_pass++;
    cyc(1);
    n_tot++;
    if (irq !== 1'b1) $display("FAIL en_irq2 got %b want 1", irq);
    else n_pass++;
  endtask

  task automatic test_service();
    claim(v);
    n_tot++;
    if (v !== 32'd1) $display("FAIL svc_claim got %h want 1", v);
    else n_pass++;
    n_tot++;
    if (irq !== 1'b0) $display("FAIL svc_irq got %b want 0", irq);
    else n_pass++;
    peek(3'd4, v);
    n_tot++;
    if (v !== 32'h21) $display("FAIL svc_stat got %h want 21", v);
    else n_pass++;
    claim(v);
    n_tot++;
    if (v !== 32'd0) $display("FAIL svc_claim2 got %h want 0", v);
    else n_pass++;
    wr(3'd3, 32'd3);
    peek(3'd4, v);
    n_tot++;
    if (v !== 32'h21) $display("FAIL svc_mis got %h want 21", v);
    else n_pass++;
    wr(3'd3, 32'd1);
    peek(3'd4, v);
    n_tot++;
    if (v !== 32'h0) $display("FAIL svc_done got %h want 0", v);
    else n_pass++;
    cyc(2);
    n_tot++;
    if (irq !== 1'b0) $display("FAIL svc_quiet got %b want 0", irq);
    else n_pass++;
  endtask

  task automatic test_priority();
    wr(3'd1, 32'hF);
    pulse(4'b0110);
    cyc(1);
    n_tot++;
    if (irq !== 1'b1) $display("FAIL pri_irq got %b want 1", irq);
    else n_pass++;
    claim(v);
    n_tot++;
    if (v !== 32'd2) $display("FAIL pri_claim got %h want 2", v);
    else n_pass++;
    n_tot++;
    if (irq !== 1'b0) $display("FAIL pri_drop got %b want 0", irq);
    else n_pass++;
    peek(3'd0, v);
    n_tot++;
    if (v !== 32'h4) $display("FAIL pri_pend got %h want 4", v);
    else n_pass++;
    wr(3'd3, 32'd2);
    cyc(1);
    n_tot++;
    if (irq !== 1'b1) $display("FAIL pri_reirq got %b want 1", irq);
    else n_pass++;
    claim(v);
    n_tot++;
    if (v !== 32'd3) $display("FAIL pri_claim2 got %h want 3", v);
    else n_pass++;
    wr(3'd3, 32'd3);
    cyc(2);
  endtask

  task automatic test_timer_service();
    pulse(4'b0001);
    cyc(1);
    claim(v);
    n_tot++;
    if (v !== 32'd1) $display("FAIL tmr_claim got %h want 1", v);
    else n_pass++;
    for (int k = 0; k < 5; k++) begin
      pulse(4'b0001);
      cyc(3);
    end
    peek(3'd0, v);
    n_tot++;
    if (v !== 32'h1) $display("FAIL tmr_pend got %h want 1", v);
    else n_pass++;
    n_tot++;
    if (irq !== 1'b0) $display("FAIL tmr_svc_irq got %b want 0", irq);
    else n_pass++;
    wr(3'd3, 32'd1);
    cyc(1);
    n_tot++;
    if (irq !== 1'b1) $display("FAIL tmr_reirq got %b want 1", irq);
    else n_pass++;
    claim(v);
    n_tot++;
    if (v !== 32'd1) $display("FAIL tmr_claim2 got %h want 1", v);
    else n_pass++;
    peek(3'd0, v);
    n_tot++;
    if (v !== 32'h0) $display("FAIL tmr_pend2 got %h want 0", v);
    else n_pass++;
    wr(3'd3, 32'd1);
    cyc(3);
    n_tot++;
    if (irq !== 1'b0) $display("FAIL tmr_once got %b want 0", irq);
    else n_pass++;
  endtask

  task automatic test_w1c_race();
    pulse(4'b1000);
    cyc(1);
    src[3] = 1'b1;
    wr(3'd0, 32'h8);
    src[3] = 1'b0;
    peek(3'd0, v);
    n_tot++;
    if (v !== 32'h8) $display("FAIL w1c_race got %h want 8", v);
    else n_pass++;
    n_tot++;
    if (irq !== 1'b1) $display("FAIL w1c_pre got %b want 1", irq);
    else n_pass++;
    wr(3'd0, 32'h8);
    cyc(1);
    n_tot++;
    if (irq !== 1'b0) $display("FAIL w1c_irq got %b want 0", irq);
    else n_pass++;
    peek(3'd0, v);
    n_tot++;
    if (v !== 32'h0) $display("FAIL w1c_pend got %h want 0", v);
    else n_pass++;
    cyc(2);
    n_tot++;
    if (irq !== 1'b0) $display("FAIL w1c_idle got %b want 0", irq);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    pulse(4'b0100);
    cyc(1);
    claim(v);
    n_tot++;
    if (v !== 32'd3) $display("FAIL ar_claim got %h want 3", v);
    else n_pass++;
    src[0] = 1'b1;
    cyc(2);
    peek(3'd0, v);
    n_tot++;
    if (v !== 32'h1) $display("FAIL ar_pre got %h want 1", v);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_tot++;
    if (irq !== 1'b0) $display("FAIL ar_irq got %b want 0", irq);
    else n_pass++;
    peek(3'd0, v);
    n_tot++;
    if (v !== 32'h0) $display("FAIL ar_pend got %h want 0", v);
    else n_pass++;
    peek(3'd4, v);
    n_tot++;
    if (v !== 32'h0) $display("FAIL ar_stat got %h want 0", v);
    else n_pass++;
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
    peek(3'd0, v);
    n_tot++;
    if (v !== 32'h0) $display("FAIL ar_level got %h want 0", v);
    else n_pass++;
    src[0] = 1'b0;
    cyc(1);
    src[0] = 1'b1;
    cyc(1);
    peek(3'd0, v);
    n_tot++;
    if (v !== 32'h1) $display("FAIL ar_reedge got %h want 1", v);
    else n_pass++;
    src[0] = 1'b0;
    cyc(1);
  endtask

  initial begin
    bus.a  = 3'd0;
    bus.d  = 32'd0;
    bus.we = 1'b0;
    bus.rd = 1'b0;
    test_reset();
    test_mask_latch();
    test_service();
    test_priority();
    test_timer_service();
    test_w1c_race();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
